ps2_rx_fifo: RTL
================

# ps2_rx_fifo

PS/2 receive front end for the BK keyboard path. It takes the raw `PS2_Clk`/`PS2_Data` pins, re-times and de-glitches them, and deframes 11-bit device-to-host frames into 8-bit scan codes. Good codes are queued for the scan-code-to-ASCII translator in `kbd_intf`, which drains them through a pop handshake. The block runs in the `clk25` domain.

## Interface
Parameters:
- `FILTER_LEN`, default 4: consecutive identical synchronized samples needed before the filtered PS/2 clock changes.
- `TIMEOUT_CYCLES`, default 12500: idle `clk25` cycles allowed between falling edges inside a frame (500 µs).
- `FIFO_DEPTH_LOG2`, default 2: FIFO depth is 2**`FIFO_DEPTH_LOG2`. Ignored without `PS2_RX_FIFO_EN`.

Ports:
- `clk25`  in  1  system clock, 25 MHz.
- `reset_in`  in  1  reset, asynchronous, active-high.
- `PS2_Clk`  in  1  raw PS/2 clock pin, asynchronous to `clk25`.
- `PS2_Data`  in  1  raw PS/2 data pin, asynchronous to `clk25`.
- `code_o`  out  8  scan code at the queue head; valid only while `code_valid_o` is high.
- `code_valid_o`  out  1  queue not empty.
- `code_rd_i`  in  1  pop the head entry; ignored when the queue is empty.
- `parity_err_o`  out  1  one-cycle pulse when a frame is rejected for parity.
- `frame_err_o`  out  1  one-cycle pulse for a bad stop bit or a timeout.
- `overflow_o`  out  1  sticky; set when a good code is dropped; cleared by `reset_in` or by any pop.
- `busy_o`  out  1  high while the deframer is not in IDLE.

## Operation
Input conditioning:
- Two-flop synchronizer on each raw pin.
- Clock filter: the filtered clock takes a new level only after `FILTER_LEN` consecutive synchronized samples at that level. Its reset value is 1.
- Data is sampled from the synchronizer output on the cycle a filtered falling edge is detected.

Deframer states:
- IDLE: on a falling edge, a data value of 0 moves to DATA with the bit count cleared. A data value of 1 is a spurious start; stay in IDLE.
- DATA: shift in 8 bits, LSB first. After the 8th bit, go to PARITY.
- PARITY: capture the bit, then go to STOP.
- STOP: stop bit 1 with odd parity over 9 bits is a good frame; push it. Odd parity failing pulses `parity_err_o`. A stop bit of 0 pulses `frame_err_o`; if parity also failed, only `frame_err_o` pulses. Always return to IDLE.

Timeout:
- The counter clears on every filtered falling edge and counts while not in IDLE.
- Reaching `TIMEOUT_CYCLES`: pulse `frame_err_o`, discard the partial frame, go to IDLE.

Queue:
- A push when full drops the new code and sets `overflow_o`.
- A push and pop in the same cycle when full pops the head and stores the new code; no overflow.
- A pop and push when empty stores the code; `code_valid_o` rises the next cycle.

Reset:
- Reset asserted mid-frame aborts the frame, empties the queue, and clears all flags.

## Timing
- Reset values: `code_o`=0x00; `code_valid_o`, `parity_err_o`, `frame_err_o`, `overflow_o`, `busy_o` all 0. Filtered clock and synchronizers are 1; deframer is in IDLE.
- A raw pin edge reaches the filtered clock after `FILTER_LEN`+2 cycles. Falling-edge detect is registered one cycle later.
- On a good frame, `code_valid_o` and `code_o` update on the cycle after the stop-bit falling-edge detect.
- The error pulses are exactly 1 cycle wide, on the same cycle a push would have occurred.
- On a pop, the head advances and `code_o`/`code_valid_o` update on the next cycle. There is no combinational path from `code_rd_i` to outputs.
- `busy_o` rises the cycle after the start-bit edge. It falls with the push or error cycle.

## Configuration
- `PS2_RX_FIFO_EN` defined: circular FIFO of 2**`FIFO_DEPTH_LOG2` entries. Read and write pointers are `FIFO_DEPTH_LOG2`+1 bits wide and wrap modulo 2×depth. Full is when the pointers differ only in the MSB.
- `PS2_RX_FIFO_EN` undefined: a single holding register, effective depth 1, with the same handshake and the same overflow and simultaneous push/pop rules.

## Test plan
- Good frame: send 0x1C (parity 0, stop 1) at a 10 kHz PS/2 clock → `code_valid_o`=1 and `code_o`=0x1C. Pulse `code_rd_i` → `code_valid_o`=0 the next cycle.
- Parity fault: send 0x1C with parity bit 1 → one `parity_err_o` pulse, `code_valid_o` stays 0, `busy_o` returns to 0.
- Timeout and recovery: send a start bit plus 3 data bits, then hold `PS2_Clk` high → `frame_err_o` pulses 12500 cycles after the last edge. A following 0xF0 frame (parity 1) is received correctly.
- Overflow (FIFO enabled, depth 4): send 0x01, 0x02, 0x03, 0x04, 0x05 with no reads → reads return 0x01 to 0x04, and `overflow_o`=1 until the first pop. Repeat with the macro undefined → only 0x01 is stored.
- Glitch and reset: inject a 2-cycle low pulse on `PS2_Clk` → no state change. Assert `reset_in` after bit 4 of a frame → all outputs 0 immediately, and the next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin conditioning, 11-bit deframing and a scan-code queue.
// Define PS2_RX_FIFO_EN for a 2**FIFO_DEPTH_LOG2 FIFO; otherwise a single holding register.
module ps2_rx_fifo #(
  parameter int FILTER_LEN      = 4,
  parameter int TIMEOUT_CYCLES  = 12500,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic       clk25,
  input  logic       reset_in,
  input  logic       PS2_Clk,
  input  logic       PS2_Data,
  output logic [7:0] code_o,
  output logic       code_valid_o,
  input  logic       code_rd_i,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overflow_o,
  output logic       busy_o
);

  // state  | meaning
  // IDLE   | waiting for a start bit (data 0 on a filtered falling edge)
  // DATA   | shifting in 8 data bits, LSB first
  // PARITY | capturing the odd-parity bit
  // STOP   | checking stop bit and parity, then push or flag an error
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  if (FIFO_DEPTH_LOG2 < 1) begin : g_depth_chk
    $error("FIFO_DEPTH_LOG2 must be at least 1");
  end

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic [FW-1:0] filt_cnt;
  logic          clk_filt, clk_filt_d, fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;

  logic          timeout, stop_ev, par_ok, push, pop;

  always_ff @(posedge clk25 or posedge reset_in) begin
    if (reset_in) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= PS2_Clk;
      clk_s2  <= clk_s1;
      data_s1 <= PS2_Data;
      data_s2 <= data_s1;
    end
  end

  // Filtered clock only moves after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk25 or posedge reset_in) begin
    if (reset_in) begin
      filt_cnt   <= '0;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      fall       <= 1'b0;
    end else begin
      clk_filt_d <= clk_filt;
      fall       <= clk_filt_d & ~clk_filt;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign timeout = (state != S_IDLE) && !fall && (to_cnt == '0);
  assign stop_ev = (state == S_STOP) && fall;
  assign par_ok  = ^{shreg, par_bit};
  assign push    = stop_ev && data_s2 && par_ok;

  always_ff @(posedge clk25 or posedge reset_in) begin
    if (reset_in) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      to_cnt       <= TW'(TIMEOUT_CYCLES - 1);
      busy_o       <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;

      // Inter-edge watchdog: reloaded on every falling edge, runs down while a frame is open.
      if (fall)
        to_cnt <= TW'(TIMEOUT_CYCLES - 1);
      else if (state != S_IDLE && to_cnt != '0)
        to_cnt <= to_cnt - 1'b1;

      if (timeout) begin
        state       <= S_IDLE;
        busy_o      <= 1'b0;
        frame_err_o <= 1'b1;
      end else if (fall) begin
        case (state)
          S_IDLE: begin
            if (!data_s2) begin
              state   <= S_DATA;
              bit_cnt <= '0;
              busy_o  <= 1'b1;
            end
          end
          S_DATA: begin
            shreg   <= {data_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7)
              state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= data_s2;
            state   <= S_STOP;
          end
          S_STOP: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
            if (!data_s2)
              frame_err_o <= 1'b1;
            else if (!par_ok)
              parity_err_o <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef PS2_RX_FIFO_EN
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  logic [7:0]               mem [DEPTH];
  logic [FIFO_DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                     full, empty, wr_en, drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {FIFO_DEPTH_LOG2{1'b0}}});
  assign pop   = code_rd_i && !empty;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk25 or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= shreg;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (pop)
        overflow_o <= 1'b0;
      else if (drop)
        overflow_o <= 1'b1;
    end
  end

  assign code_o       = mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
  assign code_valid_o = !empty;
`else
  logic [7:0] hold_q;
  logic       hold_v;

  assign pop = code_rd_i && hold_v;

  always_ff @(posedge clk25 or posedge reset_in) begin
    if (reset_in) begin
      hold_q     <= '0;
      hold_v     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (push && (!hold_v || pop)) begin
        hold_q <= shreg;
        hold_v <= 1'b1;
      end else if (pop) begin
        hold_v <= 1'b0;
      end
      if (pop)
        overflow_o <= 1'b0;
      else if (push && hold_v)
        overflow_o <= 1'b1;
    end
  end

  assign code_o       = hold_q;
  assign code_valid_o = hold_v;
`endif

endmodule
